axi_data_fifo_sync_fwft: RTL
============================

// Module: axi_data_fifo_sync_fwft
// PURPOSE
//  Parametrised synchronous data FIFO with first-word-fall-through output for the iDMA read path.
//  Storage: one two-port SRAM, 1-cycle read latency, plus a 2-entry output prefetch buffer.
//  Adds an empty-path bypass, a runtime almost-full threshold, synchronous flush, and sticky error flags.
//  Sits between the AXI R-channel unpacker (push side) and the iNoC packetiser (valid/ready pop side).
// PARAMETERS
//  DATA_WIDTH  144        payload width: 128 data bits + 16 sideband bits
//  DEPTH       64         SRAM entries; power of 2, >=4; total capacity CAP = DEPTH+2
//  ADDR_WID    clog2(DEPTH)        localparam, SRAM address width
//  CNT_WID     clog2(DEPTH+2)+1    localparam, occupancy counter width
// PORTS
//  clk           in   1           single clock
//  rst           in   1           asynchronous reset, active-high
//  push          in   1           write request
//  push_data     in   DATA_WIDTH  write payload
//  push_ready    out  1           == !full; a push is accepted only when push && push_ready
//  pop_valid     out  1           pop_data is valid (FWFT)
//  pop_ready     in   1           consumer accepts; pop fires on pop_valid && pop_ready
//  pop_data      out  DATA_WIDTH  head-of-FIFO payload
//  empty         out  1           word_cnt == 0
//  full          out  1           word_cnt == CAP
//  afull         out  1           word_cnt >= afull_thresh
//  afull_thresh  in   CNT_WID     runtime almost-full level, quasi-static
//  word_cnt      out  CNT_WID     total entries: SRAM + read in flight + output buffer
//  init          in   1           synchronous flush
//  overflow      out  1           sticky: push seen while full
//  underflow     out  1           sticky: pop_ready seen while !pop_valid and empty
// BEHAVIOUR
//  Reset: pointers, sram_cnt, word_cnt, output-buffer occupancy, in-flight flag, overflow and underflow = 0.
//   After reset: empty=1, full=0, push_ready=1, pop_valid=0, pop_data=0; afull = (afull_thresh==0).
//  word_cnt: next = cnt + push_fire - pop_fire. Simultaneous push and pop leave it unchanged.
//   Full is evaluated on the current count, so a push at full is rejected even if a pop fires the same cycle.
//  SRAM write: on push_fire when not bypassing. WADDR = wptr; wptr wraps mod DEPTH.
//  Bypass: when sram_cnt==0, no read is in flight, and buffer occupancy - pop_fire < 2, push_data goes
//   directly into the output buffer. pop_valid is high the next cycle (latency 1).
//  Prefetch read: issued when sram_cnt>0 and (buf_occ + inflight - pop_fire) < 2.
//   RADDR = rptr; rptr wraps mod DEPTH. RDATA is captured into the buffer the next cycle.
//   Via SRAM, push to pop_valid latency is 3 cycles.
//  Output buffer: 2-entry in-order queue; pop_data = head entry.
//   Sustains 1 push and 1 pop per cycle with no bubbles once primed.
//  Simultaneous SRAM read and write to the same address cannot occur: a read implies sram_cnt>0.
//  init: next cycle, all state is as after reset, except afull follows afull_thresh.
//   Any in-flight read data is discarded. A push or pop in the init cycle is ignored.
//   overflow and underflow are cleared.
//  Errors: push && full sets overflow; data is dropped and state is unchanged.
//   pop_ready && empty sets underflow; no state change.
//   Both flags hold until rst or init.
//  afull_thresh > CAP: afull is never asserted. afull_thresh == 0: afull is always 1.
// STRUCTURE
//  Shared package idma_fifo_pkg:
//   - pkg function clog2
//   - typedef of the 2-entry buffer state
//   - localparam SIDEBAND_W=16
//  Sub-module tpram_wrap #(DATA_WIDTH,DEPTH) (RCLK/RADDR/RCEB/RDATA/WCLK/WADDR/WCEB/WDATA, active-low CE):
//   maps to std_tpram64x144 when 64x144 and to a behavioural array otherwise.
//  Top: pointer/counter logic, prefetch control, output buffer, flags.
// TESTING
//  1 Reset then a single push D=0xA5 at cycle t, pop_ready=1 -> pop_valid at t+1 (bypass), pop_data=0xA5, empty at t+2.
//  2 DEPTH=8, pop_ready=0, push 10 words 0..9 -> full and word_cnt=10 after 10th.
//    11th push dropped, overflow=1. Then drain 10 pops: data 0..9 in order, empty=1.
//  3 Continuous push and pop every cycle for 1000 words with wraparound -> strictly in-order data, no bubble after the first valid.
//    word_cnt is constant in steady state.
//  4 afull_thresh=6, DEPTH=8: afull rises on the cycle word_cnt reaches 6 and falls when it drops to 5.
//    Change afull_thresh to 11 -> afull stays 0.
//  5 With 5 words queued and an SRAM read in flight, assert init -> next cycle empty=1, word_cnt=0, pop_valid=0.
//    Next push 0x3C pops as 0x3C; no stale data.
//  6 Assert rst asynchronously mid-stream (between edges) -> outputs at reset values immediately.
//    After release, fifo operates from empty.

Source files
------------

// File: rtl/idma_fifo_pkg.sv
// Shared types and helpers for the iDMA read-path data FIFO.
// Provides clog2, the output-buffer state bundle and the sideband width.
package idma_fifo_pkg;

    localparam int SIDEBAND_W = 16;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Output prefetch buffer bookkeeping: occupancy (0..2) and whether
    // an SRAM read is in flight towards it.
    typedef struct packed {
        logic [1:0] occ;
        logic       inflight;
    } buf_state_t;

endpackage

// File: rtl/tpram_wrap.sv
// Two-port SRAM wrapper: one write port, one read port, active-low enables.
// Ports: RCLK/RADDR/RCEB/RDATA (1-cycle read), WCLK/WADDR/WCEB/WDATA.
// Behavioural model with the same timing as std_tpram64x144; the hard
// macro is substituted for the 64x144 configuration in the tech build.
module tpram_wrap #(
    parameter int DATA_WIDTH = 144,
    parameter int DEPTH      = 64,
    parameter int ADDR_WID   = 6
) (
    input  logic                  RCLK,
    input  logic [ADDR_WID-1:0]   RADDR,
    input  logic                  RCEB,
    output logic [DATA_WIDTH-1:0] RDATA,
    input  logic                  WCLK,
    input  logic [ADDR_WID-1:0]   WADDR,
    input  logic                  WCEB,
    input  logic [DATA_WIDTH-1:0] WDATA
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge WCLK) begin
        if (!WCEB) begin
            mem[WADDR] <= WDATA;
        end
    end

    always_ff @(posedge RCLK) begin
        if (!RCEB) begin
            RDATA <= mem[RADDR];
        end
    end

endmodule

// File: rtl/axi_data_fifo_sync_fwft.sv
// Synchronous FWFT data FIFO: SRAM storage plus a 2-entry prefetch buffer.
// Ports: push/push_data/push_ready, pop_valid/pop_ready/pop_data,
// empty/full/afull/afull_thresh/word_cnt, init flush, sticky overflow/underflow.
module axi_data_fifo_sync_fwft
    import idma_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = 144,
    parameter  int DEPTH      = 64,
    localparam int ADDR_WID   = clog2(DEPTH),
    localparam int CNT_WID    = clog2(DEPTH + 2) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  push_ready,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full,
    output logic                  afull,
    input  logic [CNT_WID-1:0]    afull_thresh,
    output logic [CNT_WID-1:0]    word_cnt,
    input  logic                  init,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [CNT_WID-1:0] CAP = CNT_WID'(DEPTH + 2);

    logic [ADDR_WID-1:0]   wptr;
    logic [ADDR_WID-1:0]   rptr;
    logic [ADDR_WID:0]     sram_cnt;
    logic [CNT_WID-1:0]    cnt;
    buf_state_t            st;
    logic [DATA_WIDTH-1:0] buf0;
    logic [DATA_WIDTH-1:0] buf1;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] enq_data;

    logic       push_fire;
    logic       pop_fire;
    logic       bypass;
    logic       sram_wr;
    logic       sram_rd;
    logic       enq;
    logic [1:0] occ_left;
    logic [1:0] occ_pend;

    assign full       = (cnt == CAP);
    assign empty      = (cnt == '0);
    assign push_ready = !full;
    assign pop_valid  = (st.occ != 2'd0);
    assign pop_data   = buf0;
    assign word_cnt   = cnt;
    assign afull      = (cnt >= afull_thresh);

    assign push_fire = push && !full && !init;
    assign pop_fire  = pop_valid && pop_ready && !init;

    // Buffer entries remaining after this cycle's pop, and that plus
    // the read already in flight: decides bypass and new prefetches.
    assign occ_left = st.occ - {1'b0, pop_fire};
    assign occ_pend = occ_left + {1'b0, st.inflight};

    // Bypass only when nothing older sits in SRAM or in flight,
    // so ordering is preserved.
    assign bypass  = push_fire && (sram_cnt == '0) && !st.inflight
                     && (occ_left < 2'd2);
    assign sram_wr = push_fire && !bypass;
    assign sram_rd = !init && (sram_cnt != '0) && (occ_pend < 2'd2);

    // Bypass and read capture are mutually exclusive (bypass needs
    // no read in flight), so at most one enqueue per cycle.
    assign enq      = bypass || (st.inflight && !init);
    assign enq_data = st.inflight ? rdata : push_data;

    tpram_wrap #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WID   (ADDR_WID)
    ) u_ram (
        .RCLK  (clk),
        .RADDR (rptr),
        .RCEB  (!sram_rd),
        .RDATA (rdata),
        .WCLK  (clk),
        .WADDR (wptr),
        .WCEB  (!sram_wr),
        .WDATA (push_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            sram_cnt  <= '0;
            cnt       <= '0;
            st        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (init) begin
            wptr      <= '0;
            rptr      <= '0;
            sram_cnt  <= '0;
            cnt       <= '0;
            st        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (sram_wr) begin
                wptr <= wptr + ADDR_WID'(1);
            end
            if (sram_rd) begin
                rptr <= rptr + ADDR_WID'(1);
            end
            if (sram_wr && !sram_rd) begin
                sram_cnt <= sram_cnt + (ADDR_WID + 1)'(1);
            end else if (!sram_wr && sram_rd) begin
                sram_cnt <= sram_cnt - (ADDR_WID + 1)'(1);
            end
            if (push_fire && !pop_fire) begin
                cnt <= cnt + CNT_WID'(1);
            end else if (!push_fire && pop_fire) begin
                cnt <= cnt - CNT_WID'(1);
            end
            st.occ      <= occ_left + {1'b0, enq};
            st.inflight <= sram_rd;
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop_ready && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    // In-order 2-entry queue, head in buf0. A new entry lands in the
    // slot left free after this cycle's pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0 <= '0;
            buf1 <= '0;
        end else if (init) begin
            buf0 <= '0;
            buf1 <= '0;
        end else begin
            if (pop_fire) begin
                buf0 <= buf1;
            end
            if (enq) begin
                if (occ_left[0]) begin
                    buf1 <= enq_data;
                end else begin
                    buf0 <= enq_data;
                end
            end
        end
    end

endmodule
